// File: rtl/alarm_led_pkg.sv
// Shared types and parameter helpers for the alarm LED animator.
package alarm_led_pkg;

   typedef enum logic [1:0] {
      StPass,
      StChase,
      StFlash
   } state_e;

   typedef enum logic {
      DirUp,
      DirDown
   } dir_e;

   // Clock cycles per animation step.
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned step_hz);
      return clk_hz / step_hz;
   endfunction

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alarm_led_tick.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled, pulses tick on the last count.
module alarm_led_tick #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tick
);
   import alarm_led_pkg::*;

   localparam int unsigned CntW = cnt_width(DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CntMax);

   // Next count: clear dominates, otherwise wrap at DIV-1.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alarm_led_animator.sv
// LED pass-through with a hardware alarm animation: bouncing chaser, then full-bank flash.
module alarm_led_animator #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned STEP_HZ    = 10,
   parameter int unsigned LED_W      = 10,
   parameter int unsigned CHASE_LAPS = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [LED_W-1:0] led_in,
   input  logic             alarm_active,
   output logic [LED_W-1:0] led_out,
   output logic             busy
);
   import alarm_led_pkg::*;

   localparam int unsigned DIV  = calc_div(CLK_HZ, STEP_HZ);
   localparam int unsigned PosW = cnt_width(LED_W);
   localparam int unsigned LapW = cnt_width(CHASE_LAPS + 1);
   localparam logic [PosW-1:0] PosMax = PosW'(LED_W - 1);
   localparam logic [LapW-1:0] Laps   = LapW'(CHASE_LAPS);
   localparam logic [LED_W-1:0] LedOne = {{(LED_W-1){1'b0}}, 1'b1};

   if (DIV < 2) begin : g_bad_div
      $error("alarm_led_animator: CLK_HZ/STEP_HZ must be at least 2");
   end
   if (LED_W < 2) begin : g_bad_led_w
      $error("alarm_led_animator: LED_W must be at least 2");
   end
   if (CHASE_LAPS < 1) begin : g_bad_laps
      $error("alarm_led_animator: CHASE_LAPS must be at least 1");
   end

   state_e           state_q, state_d;
   dir_e             dir_q, dir_d;
   logic [PosW-1:0]  pos_q, pos_d;
   logic [LapW-1:0]  lap_q, lap_d, lap_next;
   logic [LED_W-1:0] led_q, led_d;
   logic             tick;

   // Prescaler runs only while animating; it restarts on entry and on exit.
   alarm_led_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     ((state_q == StPass) || !alarm_active),
      .en      (state_q != StPass),
      .tick    (tick)
   );

   assign lap_next = lap_q + LapW'(1);
   assign led_out  = led_q;
   assign busy     = (state_q != StPass);

   // Next-state, counters and LED word; alarm drop beats a coincident tick.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      pos_d   = pos_q;
      lap_d   = lap_q;
      led_d   = led_q;
      case (state_q)
         StPass: begin
            if (alarm_active) begin
               state_d = StChase;
               dir_d   = DirUp;
               pos_d   = '0;
               lap_d   = '0;
               led_d   = LedOne;
            end else begin
               led_d = led_in;
            end
         end
         StChase: begin
            if (!alarm_active) begin
               state_d = StPass;
               led_d   = led_in;
            end else if (tick) begin
               if (dir_q == DirUp) begin
                  if (pos_q == PosMax) begin
                     pos_d = PosMax - PosW'(1);
                     dir_d = DirDown;
                  end else begin
                     pos_d = pos_q + PosW'(1);
                  end
               end else if (pos_q > PosW'(1)) begin
                  pos_d = pos_q - PosW'(1);
               end else if (lap_next < Laps) begin
                  pos_d = '0;
                  dir_d = DirUp;
                  lap_d = lap_next;
               end else begin
                  state_d = StFlash;
               end
               led_d = (state_d == StFlash) ? '1 : (LedOne << pos_d);
            end
         end
         StFlash: begin
            if (!alarm_active) begin
               state_d = StPass;
               led_d   = led_in;
            end else if (tick) begin
               led_d = ~led_q;
            end
         end
         default: begin
            state_d = StPass;
         end
      endcase
   end

   // State, counters and output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StPass;
         dir_q   <= DirUp;
         pos_q   <= '0;
         lap_q   <= '0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         pos_q   <= pos_d;
         lap_q   <= lap_d;
         led_q   <= led_d;
      end
   end

endmodule

// File: tb/tb_alarm_led_animator.sv
// Directed bench for alarm_led_animator with DIV=10, LED_W=10, CHASE_LAPS=2.
module tb_alarm_led_animator;

   logic       clk;
   logic       reset_n;
   logic [9:0] led_in;
   logic       alarm_active;
   logic [9:0] led_out;
   logic       busy;

   int n_cmp;
   int n_err;

   alarm_led_animator #(
      .CLK_HZ     (100),
      .STEP_HZ    (10),
      .LED_W      (10),
      .CHASE_LAPS (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .led_in       (led_in),
      .alarm_active (alarm_active),
      .led_out      (led_out),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges, then settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      reset_n      = 1'b0;
      alarm_active = 1'b0;
      led_in       = 10'h2A5;

      // Reset and pass-through.
      step(3);
      check_eq("rst_led", 32'(led_out), 32'h000);
      check_eq("rst_busy", 32'(busy), 32'h0);
      reset_n = 1'b1;
      step(1);
      check_eq("pass_2a5", 32'(led_out), 32'h2A5);
      led_in = 10'h0F0;
      step(1);
      check_eq("pass_0f0", 32'(led_out), 32'h0F0);

      // Full animation; edge E is the first edge sampling the alarm.
      alarm_active = 1'b1;
      step(1);
      check_eq("e0_led", 32'(led_out), 32'h001);
      check_eq("e0_busy", 32'(busy), 32'h1);
      step(9);
      check_eq("e9_hold", 32'(led_out), 32'h001);
      step(1);
      check_eq("e10_led", 32'(led_out), 32'h002);
      step(80);
      check_eq("e90_top", 32'(led_out), 32'h200);
      step(10);
      check_eq("e100_bounce", 32'(led_out), 32'h100);
      step(80);
      check_eq("e180_lap", 32'(led_out), 32'h001);
      step(170);
      check_eq("e350_pos1", 32'(led_out), 32'h002);
      step(10);
      check_eq("e360_flash", 32'(led_out), 32'h3FF);
      check_eq("e360_busy", 32'(busy), 32'h1);
      led_in = 10'h155;
      step(10);
      check_eq("e370_off", 32'(led_out), 32'h000);
      led_in = 10'h0AA;
      step(9);
      check_eq("e379_off", 32'(led_out), 32'h000);
      step(1);
      check_eq("e380_on", 32'(led_out), 32'h3FF);

      // Asynchronous reset between edges, mid-flash.
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_rst_led", 32'(led_out), 32'h000);
      check_eq("async_rst_busy", 32'(busy), 32'h0);
      step(2);
      #2;
      reset_n = 1'b1;
      step(1);
      check_eq("rst_restart", 32'(led_out), 32'h001);
      check_eq("rst_restart_busy", 32'(busy), 32'h1);

      // Leave the alarm; pass-through resumes on the next edge.
      alarm_active = 1'b0;
      led_in       = 10'h155;
      step(1);
      check_eq("exit_led", 32'(led_out), 32'h155);
      check_eq("exit_busy", 32'(busy), 32'h0);

      // Drop at E+55 (pos 5), then re-raise to check the prescaler restart.
      alarm_active = 1'b1;
      step(1);
      step(54);
      check_eq("e54_pos5", 32'(led_out), 32'h020);
      alarm_active = 1'b0;
      led_in       = 10'h3C3;
      step(1);
      check_eq("drop55_led", 32'(led_out), 32'h3C3);
      check_eq("drop55_busy", 32'(busy), 32'h0);
      alarm_active = 1'b1;
      step(1);
      check_eq("rearm_led", 32'(led_out), 32'h001);
      step(9);
      check_eq("rearm_9", 32'(led_out), 32'h001);
      step(1);
      check_eq("rearm_10", 32'(led_out), 32'h002);

      // Drop on a tick cycle: exit wins over the chaser step.
      alarm_active = 1'b0;
      led_in       = 10'h111;
      step(1);
      check_eq("pass_111", 32'(led_out), 32'h111);
      alarm_active = 1'b1;
      step(1);
      step(49);
      check_eq("e49_pos4", 32'(led_out), 32'h010);
      alarm_active = 1'b0;
      led_in       = 10'h0AA;
      step(1);
      check_eq("tick_drop_led", 32'(led_out), 32'h0AA);
      check_eq("tick_drop_busy", 32'(busy), 32'h0);
      led_in = 10'h301;
      step(1);
      check_eq("tick_drop_follow", 32'(led_out), 32'h301);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
